serial_paralelo_sync: RTL and testbench

- Parametrised serial-to-parallel converter with comma-based word alignment and link-lock tracking.
- Single-clock successor to the fixed 8-bit converter, which needed a separate word clock.
- Hunts for the comma at any bit offset and realigns words to it.
- Declares the link active after LOCK_COUNT consecutive aligned commas; drops lock after LOSS_WORDS consecutive non-comma words.
- Sits at the receive side of the serial link, feeding the downstream parallel datapath.

---
 rtl/serial_paralelo_sync.sv | 90 +++++++++
 tb/tb_serial_paralelo_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync: serial-to-parallel converter with comma alignment and link-lock tracking
// Ports: clk_32f bit clock; reset sync active-high; data_input/valid_input serial bit (MSB first) and its qualifier;
// data_output last aligned word (first bit in MSB); valid_output one-cycle word strobe;
// active_output link locked; comma_count aligned commas counted toward lock (saturates at LOCK_COUNT).
module serial_paralelo_sync #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = 8'hBC,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_WORDS = 8,
  parameter int CW = $clog2(LOCK_COUNT+1)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_input,
  input  logic             valid_input,
  output logic [WIDTH-1:0] data_output,
  output logic             valid_output,
  output logic             active_output,
  output logic [CW-1:0]    comma_count
);
  localparam int BW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH+1);
  localparam int MW = $clog2(LOSS_WORDS+2);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t state;
  logic [WIDTH-1:0] sr, sr_next;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] fill;
  logic [MW-1:0] miss;
  logic filled, word_done, is_comma;
  assign sr_next = {sr[WIDTH-2:0], data_input};
  // detection counts the bit being sampled on this edge
  assign filled = fill >= FW'(WIDTH-1);
  assign word_done = bit_cnt == BW'(WIDTH-1);
  assign is_comma = sr_next == COMMA;
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state <= HUNT;
      sr <= '0;
      bit_cnt <= '0;
      fill <= '0;
      miss <= '0;
      data_output <= '0;
      valid_output <= 1'b0;
      active_output <= 1'b0;
      comma_count <= '0;
    end else begin
      valid_output <= 1'b0;
      if (valid_input) begin
        sr <= sr_next;
        if (fill != FW'(WIDTH)) fill <= fill + 1'b1;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        if (state == HUNT) begin
          if (filled && is_comma) begin
            data_output <= COMMA;
            valid_output <= 1'b1;
            bit_cnt <= '0;
            comma_count <= CW'(1);
            state <= (LOCK_COUNT == 1) ? LOCKED : SYNC;
            active_output <= (LOCK_COUNT == 1);
          end
        end else if (word_done) begin
          data_output <= sr_next;
          valid_output <= 1'b1;
          if (state == SYNC) begin
            if (!is_comma) begin
              state <= HUNT;
              comma_count <= '0;
            end else begin
              comma_count <= comma_count + 1'b1;
              if (comma_count + 1'b1 == CW'(LOCK_COUNT)) begin
                state <= LOCKED;
                active_output <= 1'b1;
              end
            end
          end else if (is_comma) begin
            miss <= '0;
          end else if (LOSS_WORDS != 0 && miss + 1'b1 == MW'(LOSS_WORDS)) begin
            state <= HUNT;
            active_output <= 1'b0;
            comma_count <= '0;
            miss <= '0;
          end else begin
            miss <= miss + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb_serial_paralelo_sync: directed self-checking bench for serial_paralelo_sync (8-bit and 10-bit instances)
module tb_serial_paralelo_sync;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic vin = 1'b0;
  logic [7:0] dout;
  logic vo, act;
  logic [2:0] cc;
  logic [9:0] dout10;
  logic vo10, act10;
  logic [0:0] cc10;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulses10 = 0;

  always #5 clk = ~clk;

  serial_paralelo_sync dut (
    .clk_32f(clk), .reset(rst), .data_input(din), .valid_input(vin),
    .data_output(dout), .valid_output(vo), .active_output(act), .comma_count(cc)
  );

  serial_paralelo_sync #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1)) dut10 (
    .clk_32f(clk), .reset(rst), .data_input(din), .valid_input(vin),
    .data_output(dout10), .valid_output(vo10), .active_output(act10), .comma_count(cc10)
  );

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = v[i];
      vin = 1'b1;
      @(posedge clk);
      #1;
      if (vo) pulses++;
      if (vo10) pulses10++;
    end
    vin = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vin = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vin = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({dout, vo, act, cc} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got dout=%h vo=%b act=%b cc=%0d want all zero", dout, vo, act, cc);
    end
  endtask

  task automatic test_lock();
    logic [2:0] exp_cc[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic exp_act[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulses = 0;
    send_bits(16'b01, 2);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL lock_prefix pulses got %0d want 0", pulses); end
    for (int k = 0; k < 5; k++) begin
      pulses = 0;
      send_bits(16'hBC, 8);
      total++;
      if (vo !== 1'b1 || dout !== 8'hBC || pulses !== 1) begin
        bad++; $display("FAIL lock_word%0d got vo=%b dout=%h pulses=%0d want 1 bc 1", k, vo, dout, pulses);
      end
      total++;
      if (cc !== exp_cc[k] || act !== exp_act[k]) begin
        bad++; $display("FAIL lock_count%0d got cc=%0d act=%b want cc=%0d act=%b", k, cc, act, exp_cc[k], exp_act[k]);
      end
    end
  endtask

  task automatic test_data_and_loss();
    logic [7:0] w[2] = '{8'h3C, 8'hA5};
    for (int k = 0; k < 2; k++) begin
      pulses = 0;
      send_bits({8'h00, w[k]}, 8);
      total++;
      if (vo !== 1'b1 || dout !== w[k] || act !== 1'b1 || pulses !== 1) begin
        bad++; $display("FAIL locked_data%0d got vo=%b dout=%h act=%b pulses=%0d want 1 %h 1 1", k, vo, dout, act, pulses, w[k]);
      end
    end
    send_bits(16'hBC, 8);
    for (int k = 1; k <= 8; k++) begin
      pulses = 0;
      send_bits(16'(k), 8);
      total++;
      if (vo !== 1'b1 || dout !== 8'(k) || act !== (k < 8) || pulses !== 1) begin
        bad++; $display("FAIL loss_word%0d got vo=%b dout=%h act=%b pulses=%0d want 1 %h %b 1", k, vo, dout, act, pulses, 8'(k), k < 8);
      end
    end
    total++;
    if (cc !== 3'd0) begin bad++; $display("FAIL loss_count got %0d want 0", cc); end
    pulses = 0;
    send_bits(16'h0000, 16);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL hunt_silent pulses got %0d want 0", pulses); end
    send_bits(16'hBC, 8);
    total++;
    if (pulses !== 1 || vo !== 1'b1 || dout !== 8'hBC || cc !== 3'd1 || act !== 1'b0) begin
      bad++; $display("FAIL relock_start got pulses=%0d vo=%b dout=%h cc=%0d act=%b want 1 1 bc 1 0", pulses, vo, dout, cc, act);
    end
  endtask

  task automatic test_sync_break();
    do_reset();
    send_bits(16'hBC, 8);
    total++;
    if (cc !== 3'd1 || vo !== 1'b1) begin bad++; $display("FAIL sync_c1 got cc=%0d vo=%b want 1 1", cc, vo); end
    send_bits(16'hBC, 8);
    total++;
    if (cc !== 3'd2) begin bad++; $display("FAIL sync_c2 got cc=%0d want 2", cc); end
    pulses = 0;
    send_bits(16'h00, 8);
    total++;
    if (cc !== 3'd0 || vo !== 1'b1 || dout !== 8'h00 || pulses !== 1 || act !== 1'b0) begin
      bad++; $display("FAIL sync_break got cc=%0d vo=%b dout=%h pulses=%0d act=%b want 0 1 00 1 0", cc, vo, dout, pulses, act);
    end
    send_bits(16'hBC, 8);
    total++;
    if (cc !== 3'd1 || vo !== 1'b1 || dout !== 8'hBC) begin
      bad++; $display("FAIL sync_restart got cc=%0d vo=%b dout=%h want 1 1 bc", cc, vo, dout);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) send_bits(16'hBC, 8);
    total++;
    if (act !== 1'b1) begin bad++; $display("FAIL stall_lock got act=%b want 1", act); end
    pulses = 0;
    send_bits(16'h5, 4);
    for (int k = 0; k < 3; k++) begin
      vin = 1'b0;
      din = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (vo !== 1'b0) begin bad++; $display("FAIL stall_cycle%0d vo got %b want 0", k, vo); end
    end
    send_bits(16'hA, 4);
    total++;
    if (vo !== 1'b1 || dout !== 8'h5A || pulses !== 1) begin
      bad++; $display("FAIL stall_word got vo=%b dout=%h pulses=%0d want 1 5a 1", vo, dout, pulses);
    end
    send_bits(16'hC3, 8);
    total++;
    if (vo !== 1'b1 || dout !== 8'hC3 || act !== 1'b1) begin
      bad++; $display("FAIL stall_next got vo=%b dout=%h act=%b want 1 c3 1", vo, dout, act);
    end
  endtask

  task automatic test_midword_reset();
    send_bits(16'b101, 3);
    do_reset();
    total++;
    if ({dout, vo, act, cc} !== 13'd0) begin
      bad++; $display("FAIL midreset_outputs got dout=%h vo=%b act=%b cc=%0d want all zero", dout, vo, act, cc);
    end
    pulses = 0;
    send_bits(16'b1011110, 7);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL fill_early pulses got %0d want 0", pulses); end
    send_bits(16'b0, 1);
    total++;
    if (vo !== 1'b1 || dout !== 8'hBC || cc !== 3'd1) begin
      bad++; $display("FAIL fill_detect got vo=%b dout=%h cc=%0d want 1 bc 1", vo, dout, cc);
    end
  endtask

  task automatic test_width10();
    do_reset();
    pulses10 = 0;
    send_bits(16'b01, 2);
    send_bits(16'h17C, 10);
    total++;
    if (vo10 !== 1'b1 || dout10 !== 10'h17C || act10 !== 1'b1 || cc10 !== 1'b1 || pulses10 !== 1) begin
      bad++; $display("FAIL w10_lock got vo=%b dout=%h act=%b cc=%0d pulses=%0d want 1 17c 1 1 1", vo10, dout10, act10, cc10, pulses10);
    end
    pulses10 = 0;
    send_bits(16'h155, 10);
    total++;
    if (vo10 !== 1'b1 || dout10 !== 10'h155 || act10 !== 1'b1 || pulses10 !== 1) begin
      bad++; $display("FAIL w10_data got vo=%b dout=%h act=%b pulses=%0d want 1 155 1 1", vo10, dout10, act10, pulses10);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data_and_loss();
    test_sync_break();
    test_stall();
    test_midword_reset();
    test_width10();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
